// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared types and defaults for the clock-enable controller
package clk_ctrl_pkg;

   localparam int DIV_W_DEF  = 16;
   localparam int STEP_W_DEF = 8;

   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - free-running phase counter that flags the last cycle of a tick period
module phase_counter #(
   parameter int DIV_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [DIV_W-1:0] div,
   input  logic             clr,
   output logic             wrap
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] r_ctr;
   logic [DIV_W-1:0] w_last;

   // div is never zero (the controller saturates 0 to 1), so div-1 is the final phase
   assign w_last = div - ONE;
   assign wrap   = (r_ctr == w_last);

   // count every cycle; restart at the end of a period or when a new divisor lands
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ctr <= '0;
      end else if (clr || wrap) begin
         r_ctr <= '0;
      end else begin
         r_ctr <= r_ctr + ONE;
      end
   end

endmodule

// File: rtl/clk_en_ctrl.sv
// rtl/clk_en_ctrl.sv - run/halt/step controller producing a divided core clock-enable tick
module clk_en_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = 4,
   parameter int STEP_W  = STEP_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              run,
   input  logic              halt,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_n,
   output logic              tick,
   output logic              step_done,
   output logic [1:0]        state_o,
   output logic [DIV_W-1:0]  div_o
);

   localparam logic [DIV_W-1:0]  DIV_RST_V = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   ctrl_state_t       r_state;
   logic [DIV_W-1:0]  r_div_q;
   logic [DIV_W-1:0]  r_pend_div;
   logic              r_pend_valid;
   logic [STEP_W-1:0] r_rem;
   logic              r_tick;
   logic              r_step_done;

   logic w_wrap;
   logic w_accept;
   logic w_apply;
   logic w_tick_next;
   logic w_step_ok;

   // one divisor can be in flight; a new one is refused until the pending one lands
   assign w_accept    = cfg_valid & ~r_pend_valid;
   // halted: land immediately; running: only at a period boundary so no period is distorted.
   // r_pend_valid is registered, so a wrap coincident with acceptance never applies it.
   assign w_apply     = r_pend_valid & ((r_state == S_HALT) | w_wrap);
   // RUN also needs run still high so that dropping run suppresses the tick at that same edge
   assign w_tick_next = w_wrap & ~halt &
                        ((r_state == S_STEP) | ((r_state == S_RUN) & run));
   assign w_step_ok   = step_req & (step_n != '0);

   phase_counter #(
      .DIV_W (DIV_W)
   ) u_phase (
      .CLK  (CLK),
      .RST  (RST),
      .div  (r_div_q),
      .clr  (w_apply),
      .wrap (w_wrap)
   );

   // divisor handshake: capture into pending, then move to the active divisor
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_div_q      <= DIV_RST_V;
         r_pend_div   <= DIV_RST_V;
         r_pend_valid <= 1'b0;
      end else if (w_apply) begin
         r_div_q      <= r_pend_div;
         r_pend_valid <= 1'b0;
      end else if (w_accept) begin
         r_pend_div   <= (cfg_div == '0) ? DIV_ONE : cfg_div;
         r_pend_valid <= 1'b1;
      end
   end

   // run/halt/step state machine with registered tick and step_done
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_HALT;
         r_rem       <= '0;
         r_tick      <= 1'b0;
         r_step_done <= 1'b0;
      end else begin
         r_tick      <= w_tick_next;
         r_step_done <= 1'b0;
         case (r_state)
            S_HALT: begin
               if (!halt) begin
                  if (w_step_ok) begin
                     r_state <= S_STEP;
                     r_rem   <= step_n;
                  end else if (run) begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (halt || !run) begin
                  r_state <= S_HALT;
               end
            end
            S_STEP: begin
               if (halt) begin
                  r_state <= S_HALT;
                  r_rem   <= '0;
               end else if (w_tick_next) begin
                  r_rem <= r_rem - STEP_ONE;
                  if (r_rem == STEP_ONE) begin
                     r_state     <= S_HALT;
                     r_step_done <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   assign cfg_ready = ~r_pend_valid;
   assign tick      = r_tick;
   assign step_done = r_step_done;
   assign state_o   = r_state;
   assign div_o     = r_div_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// tb/tb_clk_en_ctrl.sv - self-checking bench for clk_en_ctrl
module tb_clk_en_ctrl;

   localparam int DIV_W   = 16;
   localparam int STEP_W  = 8;
   localparam int DIV_RST = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic              cfg_valid = 1'b0;
   logic              run = 1'b0;
   logic              halt = 1'b0;
   logic              step_req = 1'b0;
   logic [STEP_W-1:0] step_n = '0;
   wire               cfg_ready;
   wire               tick;
   wire               step_done;
   wire  [1:0]        state_o;
   wire  [DIV_W-1:0]  div_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: state 0=HALT 1=RUN 2=STEP, pend<0 means nothing pending
   int m_state = 0, m_phase = 0, m_div = DIV_RST, m_pend = -1, m_rem = 0, m_tick = 0, m_done = 0;

   clk_en_ctrl #(.DIV_W(DIV_W), .DIV_RST(DIV_RST), .STEP_W(STEP_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cfg_div   (cfg_div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .run       (run),
      .halt      (halt),
      .step_req  (step_req),
      .step_n    (step_n),
      .tick      (tick),
      .step_done (step_done),
      .state_o   (state_o),
      .div_o     (div_o)
   );

   always #5 CLK = ~CLK;

   task automatic model_step();
      int wrap, tk, acc, app, nst;
      if (RST) begin
         m_state = 0; m_phase = 0; m_div = DIV_RST; m_pend = -1;
         m_rem = 0; m_tick = 0; m_done = 0;
         return;
      end
      wrap = (m_phase == m_div - 1);
      tk   = wrap && !halt && (m_state == 2 || (m_state == 1 && run));
      acc  = cfg_valid && (m_pend < 0);
      app  = (m_pend >= 0) && (m_state == 0 || wrap);
      m_done = 0;
      nst = m_state;
      case (m_state)
         0: if (!halt) begin
               if (step_req && step_n != 0) begin nst = 2; m_rem = int'(step_n); end
               else if (run) nst = 1;
            end
         1: if (halt || !run) nst = 0;
         2: if (halt) begin nst = 0; m_rem = 0; end
            else if (tk) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) begin nst = 0; m_done = 1; end
            end
         default: nst = 0;
      endcase
      m_phase = (wrap || app) ? 0 : m_phase + 1;
      if (app) begin m_div = m_pend; m_pend = -1; end
      else if (acc) m_pend = (cfg_div == 0) ? 1 : int'(cfg_div);
      m_state = nst;
      m_tick  = tk;
   endtask

   task automatic clk_step();
      model_step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      RST = 1'b1; run = 1'b0; halt = 1'b0; step_req = 1'b0; cfg_valid = 1'b0;
      clk_step();
      clk_step();
      RST = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({tick, step_done, state_o, cfg_ready, div_o} !== {1'b0, 1'b0, 2'd0, 1'b1, 16'd4}) begin
         n_err++;
         $display("FAIL reset_vals: got t=%b d=%b s=%0d r=%b div=%0d expected t=0 d=0 s=0 r=1 div=4",
                  tick, step_done, state_o, cfg_ready, div_o);
      end
   endtask

   task automatic test_run_from_reset();
      logic [31:0] seen = '0;
      logic [31:0] exp_t = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12);
      do_reset();
      run = 1'b1;
      repeat (14) begin
         clk_step();
         if (tick) seen[cyc] = 1'b1;
      end
      n_vec++;
      if (seen !== exp_t) begin
         n_err++; $display("FAIL run_ticks: got %h expected %h", seen, exp_t);
      end
      n_vec++;
      if (state_o !== 2'd1 || div_o !== 16'd4) begin
         n_err++; $display("FAIL run_state: got s=%0d div=%0d expected s=1 div=4", state_o, div_o);
      end
   endtask

   task automatic test_div_zero();
      int nt = 0;
      run = 1'b0;
      clk_step();
      n_vec++;
      if (state_o !== 2'd0) begin
         n_err++; $display("FAIL run_drop: got s=%0d expected s=0", state_o);
      end
      cfg_div = '0; cfg_valid = 1'b1;
      clk_step();
      cfg_valid = 1'b0;
      n_vec++;
      if (cfg_ready !== 1'b0) begin
         n_err++; $display("FAIL zero_ready_low: got %b expected 0", cfg_ready);
      end
      clk_step();
      n_vec++;
      if (cfg_ready !== 1'b1 || div_o !== 16'd1) begin
         n_err++; $display("FAIL zero_apply: got r=%b div=%0d expected r=1 div=1", cfg_ready, div_o);
      end
      run = 1'b1;
      clk_step();
      repeat (6) begin
         clk_step();
         if (tick) nt++;
      end
      n_vec++;
      if (nt != 6) begin
         n_err++; $display("FAIL div1_ticks: got %0d expected 6", nt);
      end
   endtask

   task automatic test_div_change();
      logic [31:0] seen = '0;
      logic [31:0] nrdy = '0;
      logic [31:0] exp_t = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 14) | (32'd1 << 20);
      logic [31:0] exp_r = (32'd1 << 6) | (32'd1 << 7);
      do_reset();
      run = 1'b1;
      repeat (22) begin
         if (cyc == 5) begin cfg_div = 16'd6; cfg_valid = 1'b1; end
         clk_step();
         cfg_valid = 1'b0;
         if (tick) seen[cyc] = 1'b1;
         if (!cfg_ready) nrdy[cyc] = 1'b1;
      end
      n_vec++;
      if (seen !== exp_t) begin
         n_err++; $display("FAIL change_ticks: got %h expected %h", seen, exp_t);
      end
      n_vec++;
      if (nrdy !== exp_r || div_o !== 16'd6) begin
         n_err++; $display("FAIL change_ready: got %h div=%0d expected %h div=6", nrdy, div_o, exp_r);
      end
   endtask

   task automatic test_step();
      logic [31:0] seen = '0;
      logic [31:0] dn = '0;
      logic [31:0] exp_t = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12);
      int bad = 0;
      do_reset();
      step_req = 1'b1; step_n = 8'd3;
      clk_step();
      step_req = 1'b0;
      n_vec++;
      if (state_o !== 2'd2) begin
         n_err++; $display("FAIL step_enter: got s=%0d expected s=2", state_o);
      end
      repeat (15) begin
         clk_step();
         if (tick) seen[cyc] = 1'b1;
         if (step_done) dn[cyc] = 1'b1;
      end
      n_vec++;
      if (seen !== exp_t || dn !== (32'd1 << 12)) begin
         n_err++; $display("FAIL step_ticks: got t=%h d=%h expected t=%h d=%h", seen, dn, exp_t, 32'd1 << 12);
      end
      n_vec++;
      if (state_o !== 2'd0) begin
         n_err++; $display("FAIL step_exit: got s=%0d expected s=0", state_o);
      end
      step_req = 1'b1; step_n = 8'd0;
      clk_step();
      step_req = 1'b0;
      repeat (10) begin
         if (tick || step_done || state_o != 2'd0) bad++;
         clk_step();
      end
      n_vec++;
      if (bad != 0) begin
         n_err++; $display("FAIL step_zero: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_halt_wrap();
      logic [31:0] seen = '0;
      logic [31:0] exp_t = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 16) | (32'd1 << 20);
      logic [1:0]  s12 = 2'd3;
      do_reset();
      run = 1'b1;
      repeat (20) begin
         halt = (cyc == 11);
         clk_step();
         if (tick) seen[cyc] = 1'b1;
         if (cyc == 12) s12 = state_o;
      end
      halt = 1'b0;
      n_vec++;
      if (seen !== exp_t || s12 !== 2'd0 || state_o !== 2'd1) begin
         n_err++; $display("FAIL halt_wrap: got t=%h s12=%0d s=%0d expected t=%h s12=0 s=1",
                           seen, s12, state_o, exp_t);
      end
   endtask

   task automatic test_reset_mid_step();
      logic [31:0] seen = '0;
      logic [31:0] dn = '0;
      do_reset();
      step_n = 8'd5;
      repeat (16) begin
         step_req = (cyc == 0);
         if (cyc == 9) begin cfg_div = 16'd8; cfg_valid = 1'b1; end
         RST = (cyc == 10);
         clk_step();
         cfg_valid = 1'b0; step_req = 1'b0; RST = 1'b0;
         if (tick) seen[cyc] = 1'b1;
         if (step_done) dn[cyc] = 1'b1;
         if (cyc == 11) begin
            n_vec++;
            if ({tick, step_done, state_o, cfg_ready, div_o} !== {1'b0, 1'b0, 2'd0, 1'b1, 16'd4}) begin
               n_err++;
               $display("FAIL rst_mid: got t=%b d=%b s=%0d r=%b div=%0d expected t=0 d=0 s=0 r=1 div=4",
                        tick, step_done, state_o, cfg_ready, div_o);
            end
         end
      end
      n_vec++;
      if (seen !== ((32'd1 << 4) | (32'd1 << 8)) || dn !== 32'd0 || div_o !== 16'd4 || cfg_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_after: got t=%h d=%h div=%0d r=%b expected t=%h d=0 div=4 r=1",
                           seen, dn, div_o, cfg_ready, (32'd1 << 4) | (32'd1 << 8));
      end
   endtask

   task automatic test_random();
      logic [20:0] exp_v;
      int was_ready;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 14) == 0) run = ~run;
         halt     = ($urandom_range(0, 11) == 0);
         step_req = ($urandom_range(0, 7) == 0);
         step_n   = STEP_W'($urandom_range(0, 4));
         RST      = ($urandom_range(0, 299) == 0);
         if (!cfg_valid && $urandom_range(0, 5) == 0) begin
            cfg_valid = 1'b1;
            cfg_div   = DIV_W'($urandom_range(0, 6));
         end
         was_ready = (m_pend < 0);
         clk_step();
         if (cfg_valid && was_ready) cfg_valid = 1'b0;
         exp_v = {1'(m_tick), 1'(m_done), 2'(m_state), 1'(m_pend < 0), 16'(m_div)};
         n_vec++;
         if ({tick, step_done, state_o, cfg_ready, div_o} !== exp_v) begin
            n_err++;
            $display("FAIL random cyc %0d: got {t,d,s,r,div}=%h expected %h", i,
                     {tick, step_done, state_o, cfg_ready, div_o}, exp_v);
         end
      end
      RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_from_reset();
      test_div_zero();
      test_div_change();
      test_step();
      test_halt_wrap();
      test_reset_mid_step();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clk_en_ctrl.md
Name: clk_en_ctrl

Overview:
- Run/halt/single-step controller that generates the core's clock-enable tick with a runtime-programmable divide ratio.
- It replaces fixed-ratio derived clocks: all logic stays on CLK and downstream registers qualify on tick.
- Sits between the board/debug interface (run, halt, step, divisor writes) and the CPU pipeline enable.
- Divisor changes are handshaked and applied only on a period boundary, so no short or long tick period ever occurs.

Parameters:
DIV_W, 16, width of divisor and phase counter
DIV_RST, 4, divisor loaded at reset (1 <= DIV_RST <= 2^DIV_W-1)
STEP_W, 8, width of step-count request

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
cfg_div  input  DIV_W  requested divisor; 0 is treated as 1
cfg_valid  input  1  divisor write request
cfg_ready  output  1  controller can accept a divisor
run  input  1  level: free-run ticks
halt  input  1  level: stop ticks (highest priority)
step_req  input  1  pulse: issue step_n ticks from HALT
step_n  input  STEP_W  number of ticks for a step request
tick  output  1  one-CLK-wide core enable, registered
step_done  output  1  one-cycle pulse on the final step tick
state_o  output  2  current state (HALT=0, RUN=1, STEP=2)
div_o  output  DIV_W  divisor currently in effect

Behaviour:
- Reset values: state=HALT, ctr=0, div_q=DIV_RST, no pending change, rem=0, tick=0, step_done=0, cfg_ready=1, div_o=DIV_RST.
- RST asserted mid-operation (RUN, STEP, pending change) discards all state and returns to the reset values; step_done is not pulsed.
- Phase counter:
  - ctr increments every cycle in all states.
  - wrap = (ctr == div_q-1); at wrap, ctr <= 0.
  - div_q=1 gives wrap every cycle.
- Tick generation:
  - tick <= wrap & (state==RUN | state==STEP) & ~halt.
  - Tick period equals div_q cycles exactly; in steady RUN, tick is high 1 cycle in every div_q.
- FSM (registered state; priority halt > step_req > run):
  - HALT->RUN: run & ~halt.
  - HALT->STEP: step_req & ~halt & step_n!=0; load rem<=step_n.
  - step_req with step_n==0, or step_req outside HALT, is ignored.
  - RUN->HALT: halt | ~run. No tick in any cycle after the edge at which halt or ~run was sampled.
  - STEP: each tick edge decrements rem. The edge that issues the final tick (rem==1) sets state<=HALT and step_done<=1, so step_done is coincident with the final tick.
  - STEP with halt: abort to HALT, rem<=0, no step_done.
  - run is ignored during STEP.
- Divisor handshake:
  - Transfer occurs when cfg_valid & cfg_ready; the value is stored as pending and cfg_ready drops until it is applied.
  - In HALT: pending is applied at the next edge, ctr<=0, and cfg_ready returns the following cycle.
  - In RUN/STEP: pending is applied at the first wrap edge strictly after acceptance, not one coincident with acceptance. At that edge div_q<=pending and ctr<=0; the next period uses the new divisor.
  - cfg_valid while cfg_ready=0 is held by the requester (standard valid/ready); the value must remain stable until accepted.
  - Simultaneous acceptance and a RUN->HALT transition: apply per HALT rule on the following edge.
- Width rules:
  - cfg_div==0 stores 1.
  - ctr never exceeds div_q-1; after div_q shrinks, ctr is zeroed at the apply edge, so no overrun is possible.

Decomposition:
- Package clk_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {S_HALT=0, S_RUN=1, S_STEP=2}
  - localparam defaults for DIV_W and STEP_W
- One natural sub-module, phase_counter (parameter DIV_W). Inputs: CLK, RST, div, clr. Output: wrap. It holds ctr.
- The FSM, handshake and step logic live in clk_en_ctrl.

Test Plan:
- Reset, then run=1 from cycle 0 with DIV_RST=4 -> tick high on cycles 4, 8, 12; state_o=1; div_o=4.
- In HALT, write cfg_div=0, then run -> cfg_ready low for exactly 1 cycle; div_o=1; tick high every cycle.
- RUN at div 4, write cfg_div=6 mid-period -> remaining ticks of the current period keep 4-cycle spacing; the next spacing is 6; no gap of 5 or 7; cfg_ready returns after the wrap.
- HALT, step_req with step_n=3, div 4 -> exactly 3 ticks 4 cycles apart; step_done coincident with the 3rd tick; state_o returns to 0; step_n=0 produces nothing.
- RUN, halt asserted for 1 cycle coincident with wrap -> no tick at that edge or after; state_o=0; run still high causes re-entry to RUN after halt drops.
- STEP with step_n=5 and pending cfg_div=8, RST asserted after 2 ticks -> all outputs at reset values, div_o=4, no step_done, cfg_ready=1.
